dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- AW, 6, word-address width of the shared data memory.
- DW, 32, data width.
- STARVE_MAX, 4, maximum number of consecutive cycles the display port may be denied while requesting.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low reset.
- cpu_req, in, 1, processor requests a memory access.
- cpu_we, in, 1, processor access is a write.
- cpu_addr, in, AW, processor word address.
- cpu_wdata, in, DW, processor write data.
- cpu_gnt, out, 1, processor access accepted this cycle.
- cpu_rvalid, out, 1, processor read data valid.
- cpu_rdata, out, DW, processor read data.
- vga_req, in, 1, display reader requests a read.
- vga_addr, in, AW, display read address.
- vga_gnt, out, 1, display access accepted this cycle.
- vga_rvalid, out, 1, display read data valid.
- vga_rdata, out, DW, display read data.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 1, memory write strobe.
- mem_addr, out, AW, memory address.
- mem_wdata, out, DW, memory write data.
- mem_rdata, in, DW, memory read data; synchronous, valid one cycle after mem_en with mem_we=0.
- owner, out, 2, current FSM state encoding, for debug.

Function
REQ-003 The block SHALL grant at most one requester per cycle; cpu_gnt and vga_gnt are combinational from the current requests and registered state, never both 1.
REQ-004 If exactly one requester has its request high, the block SHALL grant that requester in the same cycle.
REQ-005 If both requests are high, the block SHALL grant the CPU unless starve_cnt equals STARVE_MAX, in which case it SHALL grant the display.
REQ-006 The starve_cnt register SHALL be cleared when vga_req=0 or vga_gnt=1, SHALL increment when vga_req=1 and vga_gnt=0, and SHALL saturate at STARVE_MAX.
REQ-007 In a granted cycle, the block SHALL drive mem_en=1 and mem_addr from the winner's address; mem_we SHALL equal cpu_we for a CPU grant and 0 for a display grant; mem_wdata SHALL equal cpu_wdata on a CPU write and 0 otherwise.
REQ-008 In a cycle with no grant, the block SHALL drive mem_en, mem_we, mem_addr and mem_wdata to 0.
REQ-009 The block SHALL implement a state machine with states IDLE=0, RD_CPU=1, RD_VGA=2 and WR_CPU=3, updated every cycle from the current grant:
- CPU read grant -> RD_CPU.
- CPU write grant -> WR_CPU.
- display grant -> RD_VGA.
- no grant -> IDLE.
REQ-010 In state RD_CPU, the block SHALL assert cpu_rvalid=1 and capture mem_rdata into the cpu_rdata register; in RD_VGA, it SHALL do the same for vga_rvalid and vga_rdata. Read latency is exactly 1 cycle from grant.
REQ-011 The cpu_rdata and vga_rdata outputs SHALL hold their last captured value until the next rvalid for that port.
REQ-012 The cpu_rvalid and vga_rvalid outputs SHALL be 0 in IDLE and WR_CPU; writes produce no response.
REQ-013 A new grant SHALL be allowed in the same cycle as the rvalid of the previous read, giving back-to-back throughput of 1 access per cycle.
REQ-014 Requesters SHALL hold req, addr, we and wdata stable until gnt; the block does not latch requests and does not act on a request that drops before it is granted.
REQ-015 With vga_req held high and cpu_req held high continuously, the display SHALL be granted exactly once every STARVE_MAX+1 cycles.

Reset
REQ-016 While reset=0, asynchronously, the block SHALL set the state to IDLE, starve_cnt to 0, and cpu_rdata and vga_rdata to 0; all gnt, rvalid and mem_* outputs SHALL be 0 and owner SHALL be 0.
REQ-017 If reset is asserted in the cycle after a read grant, the pending rvalid SHALL be discarded and SHALL NOT appear after reset is released.
REQ-018 On the first clock edge after reset is released, the block SHALL arbitrate normally.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- CPU write: cpu_req=1, cpu_we=1, cpu_addr=5, cpu_wdata=0xDEADBEEF -> same cycle: cpu_gnt=1, mem_en=1, mem_we=1, mem_addr=5; next cycle: cpu_rvalid=0, owner=3.
- CPU read: cpu_req=1, cpu_we=0, cpu_addr=5, memory returns 0xDEADBEEF -> cpu_gnt=1; next cycle: cpu_rvalid=1 and cpu_rdata=0xDEADBEEF, held after the read.
- Contention with STARVE_MAX=4: both requests held high for 10 cycles -> vga_gnt=1 in cycles 5 and 10 only; cpu_gnt=1 in all other cycles; never both grants high.
- Display alone: vga_req=1, vga_addr=12 for 3 cycles -> vga_gnt=1 in each cycle; vga_rvalid=1 in cycles 2-4; starve_cnt stays 0.
- Reset mid-read: CPU read granted, then reset=0 in the next cycle -> cpu_rvalid=0, cpu_rdata=0, owner=0; no rvalid after release.
- Idle: both requests 0 -> all mem_* outputs 0, owner=0, rdata outputs unchanged.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the shared memory.
// The arb modport is the arbiter's view; env is the view of the requesters and memory.
interface dmem_arbiter_if #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_gnt;
   logic          vga_rvalid;
   logic [DW-1:0] vga_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [1:0]    owner;

   modport arb (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, owner
   );

   modport env (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, owner
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported synchronous data memory: CPU has priority,
// the display port is forced through after STARVE_MAX consecutive denied cycles.
module dmem_arbiter #(
   parameter int unsigned AW         = 6,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   dmem_arbiter_if.arb bus
);

   localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_CPU = 2'd1,
      RD_VGA = 2'd2,
      WR_CPU = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] vga_rdata_q, vga_rdata_d;

   logic          cpu_gnt_c, vga_gnt_c;
   logic          cpu_rvalid_c, vga_rvalid_c;
   logic          mem_en_c, mem_we_c;
   logic [AW-1:0] mem_addr_c;
   logic [DW-1:0] mem_wdata_c;
   logic          starve_hit_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         cpu_rdata_q  <= '0;
         vga_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_rdata_q  <= cpu_rdata_d;
         vga_rdata_q  <= vga_rdata_d;
      end
   end

   // Grant, memory strobes, next state and read-return capture.
   always_comb begin
      state_d      = IDLE;
      starve_cnt_d = '0;
      cpu_rdata_d  = cpu_rdata_q;
      vga_rdata_d  = vga_rdata_q;
      cpu_gnt_c    = 1'b0;
      vga_gnt_c    = 1'b0;
      cpu_rvalid_c = 1'b0;
      vga_rvalid_c = 1'b0;
      mem_en_c     = 1'b0;
      mem_we_c     = 1'b0;
      mem_addr_c   = '0;
      mem_wdata_c  = '0;
      starve_hit_c = (starve_cnt_q == CW'(STARVE_MAX));

      // Grants are suppressed while reset is held so no memory access leaks out.
      if (reset) begin
         vga_gnt_c = bus.vga_req && (!bus.cpu_req || starve_hit_c);
         cpu_gnt_c = bus.cpu_req && !vga_gnt_c;
      end

      if (cpu_gnt_c) begin
         mem_en_c    = 1'b1;
         mem_we_c    = bus.cpu_we;
         mem_addr_c  = bus.cpu_addr;
         mem_wdata_c = bus.cpu_we ? bus.cpu_wdata : '0;
         state_d     = bus.cpu_we ? WR_CPU : RD_CPU;
      end else if (vga_gnt_c) begin
         mem_en_c   = 1'b1;
         mem_addr_c = bus.vga_addr;
         state_d    = RD_VGA;
      end

      if (bus.vga_req && !vga_gnt_c) begin
         starve_cnt_d = starve_hit_c ? starve_cnt_q : starve_cnt_q + CW'(1);
      end

      // Memory data arrives the cycle after a read grant; forward it and keep a copy.
      if (state_q == RD_CPU) begin
         cpu_rvalid_c = 1'b1;
         cpu_rdata_d  = bus.mem_rdata;
      end
      if (state_q == RD_VGA) begin
         vga_rvalid_c = 1'b1;
         vga_rdata_d  = bus.mem_rdata;
      end
   end

   assign bus.cpu_gnt    = cpu_gnt_c;
   assign bus.vga_gnt    = vga_gnt_c;
   assign bus.cpu_rvalid = cpu_rvalid_c;
   assign bus.vga_rvalid = vga_rvalid_c;
   assign bus.cpu_rdata  = cpu_rdata_d;
   assign bus.vga_rdata  = vga_rdata_d;
   assign bus.mem_en     = mem_en_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.owner      = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous memory.
module tb_dmem_arbiter;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 32;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
   endtask

   task automatic drive_vga(input logic req, input logic [AW-1:0] addr);
      bus.vga_req  = req;
      bus.vga_addr = addr;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'hA000_0000 + i);
      mem[12] = 32'h1234_5678;
      bus.mem_rdata = '0;
      reset = 1'b0;
      drive_cpu(1'b1, 1'b0, 6'd3, 32'h0);
      drive_vga(1'b1, 6'd12);

      // Reset: requests high but nothing may be granted.
      #12;
      check("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
      check("rst_vga_gnt", 64'(bus.vga_gnt), 64'd0);
      check("rst_mem_en", 64'(bus.mem_en), 64'd0);
      check("rst_owner", 64'(bus.owner), 64'd0);
      check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
      check("rst_vga_rdata", 64'(bus.vga_rdata), 64'd0);
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      drive_vga(1'b0, 6'd0);
      reset = 1'b1;

      // CPU write.
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
      #1;
      check("wr_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
      check("wr_vga_gnt", 64'(bus.vga_gnt), 64'd0);
      check("wr_mem_en", 64'(bus.mem_en), 64'd1);
      check("wr_mem_we", 64'(bus.mem_we), 64'd1);
      check("wr_mem_addr", 64'(bus.mem_addr), 64'd5);
      check("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      check("wr_rvalid", 64'(bus.cpu_rvalid), 64'd0);
      check("wr_owner", 64'(bus.owner), 64'd3);

      // CPU read of the word just written.
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 6'd5, 32'h0);
      #1;
      check("rd_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
      check("rd_mem_we", 64'(bus.mem_we), 64'd0);
      check("rd_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      check("rd_rvalid", 64'(bus.cpu_rvalid), 64'd1);
      check("rd_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
      check("rd_owner", 64'(bus.owner), 64'd1);

      // Idle: memory strobes quiet, read data held.
      @(negedge clk);
      #1;
      check("idle_rvalid", 64'(bus.cpu_rvalid), 64'd0);
      check("idle_rdata_hold", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);
      check("idle_mem_en", 64'(bus.mem_en), 64'd0);
      check("idle_mem_we", 64'(bus.mem_we), 64'd0);
      check("idle_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("idle_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("idle_owner", 64'(bus.owner), 64'd0);
      check("idle_vga_rdata", 64'(bus.vga_rdata), 64'd0);

      // Contention: display forced through on cycles 5 and 10.
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         drive_cpu(1'b1, 1'b0, 6'd7, 32'h0);
         drive_vga(1'b1, 6'd12);
         #1;
         check($sformatf("cont_vga_gnt_%0d", i), 64'(bus.vga_gnt),
               64'((i == 5) || (i == 10)));
         check($sformatf("cont_cpu_gnt_%0d", i), 64'(bus.cpu_gnt),
               64'(!((i == 5) || (i == 10))));
         if (i == 5) check("cont_mem_addr_5", 64'(bus.mem_addr), 64'd12);
         if (i == 6) check("cont_vga_rvalid_6", 64'(bus.vga_rvalid), 64'd1);
         if (i == 6) check("cont_vga_rdata_6", 64'(bus.vga_rdata), 64'h1234_5678);
         if (i == 7) check("cont_cpu_rdata_7", 64'(bus.cpu_rdata), 64'hA000_0007);
      end
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      drive_vga(1'b0, 6'd0);
      #1;
      check("cont_vga_rvalid_end", 64'(bus.vga_rvalid), 64'd1);

      // Display alone for three cycles.
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         drive_vga(i <= 3, 6'd12);
         #1;
         check($sformatf("vga_gnt_%0d", i), 64'(bus.vga_gnt), 64'(i <= 3));
         check($sformatf("vga_rvalid_%0d", i), 64'(bus.vga_rvalid), 64'(i >= 2));
         check($sformatf("vga_starve_%0d", i), 64'(dut.starve_cnt_q), 64'd0);
      end
      check("vga_rdata_hold", 64'(bus.vga_rdata), 64'h1234_5678);

      // Reset in the cycle after a CPU read grant.
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 6'd5, 32'h0);
      #1;
      check("rmr_gnt", 64'(bus.cpu_gnt), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rmr_rvalid", 64'(bus.cpu_rvalid), 64'd0);
      check("rmr_rdata", 64'(bus.cpu_rdata), 64'd0);
      check("rmr_owner", 64'(bus.owner), 64'd0);
      check("rmr_gnt_in_reset", 64'(bus.cpu_gnt), 64'd0);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("rmr_no_late_rvalid", 64'(bus.cpu_rvalid), 64'd0);

      // Normal arbitration straight after release.
      drive_cpu(1'b1, 1'b0, 6'd5, 32'h0);
      #1;
      check("post_rst_gnt", 64'(bus.cpu_gnt), 64'd1);
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      check("post_rst_rvalid", 64'(bus.cpu_rvalid), 64'd1);
      check("post_rst_rdata", 64'(bus.cpu_rdata), 64'hDEAD_BEEF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
